// File: rtl/ym_write_scheduler.sv
// Round-robin arbiter and write sequencer for the YM2151 register port.
// Ports: sys_clk/sys_rst, req0_*/req1_* handshakes, ym_* bus, idle, timeout_err.
module ym_write_scheduler #(
  parameter int WR_PULSE     = 4,
  parameter int PHASE_GAP    = 2,
  parameter int BUSY_HOLDOFF = 2,
  parameter int BUSY_TIMEOUT = 2048
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  output logic       ym_a0,
  output logic [7:0] ym_d,
  input  logic       ym_busy,
  output logic       idle,
  output logic       timeout_err
);

  localparam int M01 = (WR_PULSE > PHASE_GAP) ? WR_PULSE : PHASE_GAP;
  localparam int M23 = (BUSY_HOLDOFF > BUSY_TIMEOUT) ?
                       BUSY_HOLDOFF : BUSY_TIMEOUT;
  localparam int MAXP = (M01 > M23) ? M01 : M23;
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] WR_LAST   = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(PHASE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(BUSY_HOLDOFF - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_BUSY = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    d_q, d_d;
  logic          err_q, err_d;
  logic          grant0, grant1;
  logic          strobe;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = !sys_rst && (state_q == S_IDLE) && grant0;
  assign req1_ready = !sys_rst && (state_q == S_IDLE) && grant1;

  assign strobe      = (state_q == S_ADDR) || (state_q == S_DATA);
  assign ym_cs_n     = !strobe;
  assign ym_wr_n     = !strobe;
  assign ym_a0       = (state_q == S_DATA);
  assign ym_d        = d_q;
  assign idle        = (state_q == S_IDLE);
  assign timeout_err = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    d_d     = d_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          last_d  = req1_ready;
          reg_d   = req1_ready ? req1_reg : req0_reg;
          dat_d   = req1_ready ? req1_data : req0_data;
          d_d     = reg_d;
        end
      end
      S_ADDR: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          d_d     = dat_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == WR_LAST) begin
          state_d = (BUSY_HOLDOFF == 0) ? S_BUSY : S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (!ym_busy) begin
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      reg_q   <= '0;
      dat_q   <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

endmodule
